// File: rtl/bus_pkg.sv
// Shared types and defaults for the fabric peripheral bus initiator.
package bus_pkg;

   localparam int unsigned BUS_ADDR_W = 24;
   localparam int unsigned BUS_DATA_W = 32;

   typedef struct packed {
      logic                    we;
      logic [BUS_DATA_W/8-1:0] be;
      logic [BUS_ADDR_W-1:0]   addr;
      logic [BUS_DATA_W-1:0]   wdata;
   } bus_cmd_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RSP
   } bus_state_e;

   // Timeout counter width: enough to hold limit, never narrower than 8 bits.
   function automatic int unsigned cnt_width(input int unsigned limit);
      return ($clog2(limit + 1) > 8) ? $clog2(limit + 1) : 8;
   endfunction

endpackage

// File: rtl/bus_cmd_fifo.sv
// Synchronous command FIFO with full/empty flags and asynchronous active-high reset.
module bus_cmd_fifo
   import bus_pkg::*;
#(
   parameter type         T     = bus_cmd_t,
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_data,
   output logic o_full,
   output logic o_empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   T                 r_mem [DEPTH];
   logic [PTR_W:0]   r_wr_ptr;
   logic [PTR_W:0]   r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign o_data    = r_mem[r_rd_ptr[PTR_W-1:0]];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
         end
      end
   end

endmodule

// File: rtl/bus_initiator.sv
// Peripheral bus initiator: queues user commands, issues them one at a time, returns completions.
// Optional GNT/RVALID timeout enabled by defining BUS_TIMEOUT_EN.
module bus_initiator
   import bus_pkg::*;
#(
   parameter int unsigned ADDR_W    = BUS_ADDR_W,
   parameter int unsigned DATA_W    = BUS_DATA_W,
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_we,
   input  logic [DATA_W/8-1:0] cmd_be,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_we,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                REQ,
   output logic                WE,
   output logic [DATA_W/8-1:0] BE,
   output logic [ADDR_W-1:0]   ADDR,
   output logic [DATA_W-1:0]   WDATA,
   input  logic                GNT,
   input  logic                RVALID,
   input  logic [DATA_W-1:0]   RDATA
);

   localparam int unsigned BE_W = DATA_W / 8;

   typedef struct packed {
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
      $error("bus_initiator: CMD_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
   end

   cmd_t              w_push_cmd;
   cmd_t              w_head;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;

   bus_state_e        r_state;
   logic              r_rdy_en;
   logic              r_req;
   logic              r_we;
   logic [BE_W-1:0]   r_be;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_rsp_valid;
   logic              r_rsp_we;
   logic [DATA_W-1:0] r_rsp_rdata;

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned CNT_W = cnt_width(TIMEOUT);
   logic [CNT_W-1:0]  r_cnt;
   logic              r_rsp_err;
   logic              w_expired;

   // Expires on the TIMEOUT-th cycle spent in REQ or WAIT.
   assign w_expired = (r_cnt == CNT_W'(TIMEOUT - 1));
   assign rsp_err   = r_rsp_err;
`else
   assign rsp_err   = 1'b0;
`endif

   // Ready is held low until the first clock after reset release.
   assign cmd_ready  = r_rdy_en & ~w_full;
   assign w_push     = cmd_valid & cmd_ready;
   assign w_pop      = (r_state == S_IDLE) & ~w_empty;
   assign w_push_cmd = '{we: cmd_we, be: cmd_be, addr: cmd_addr, wdata: cmd_wdata};

   bus_cmd_fifo #(
      .T     (cmd_t),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_push_cmd),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rdy_en    <= 1'b0;
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_be        <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_we    <= 1'b0;
         r_rsp_rdata <= '0;
`ifdef BUS_TIMEOUT_EN
         r_cnt       <= '0;
         r_rsp_err   <= 1'b0;
`endif
      end else begin
         r_rdy_en <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_req   <= 1'b1;
                  r_we    <= w_head.we;
                  r_be    <= w_head.be;
                  r_addr  <= w_head.addr;
                  r_wdata <= w_head.wdata;
                  r_state <= S_REQ;
`ifdef BUS_TIMEOUT_EN
                  r_cnt   <= '0;
`endif
               end
            end
            S_REQ: begin
               if (GNT) begin
                  r_req <= 1'b0;
                  if (RVALID) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_we    <= r_we;
                     r_rsp_rdata <= r_we ? '0 : RDATA;
`ifdef BUS_TIMEOUT_EN
                     r_rsp_err   <= 1'b0;
`endif
                     r_state     <= S_RSP;
                  end else begin
                     r_state <= S_WAIT;
`ifdef BUS_TIMEOUT_EN
                     r_cnt   <= '0;
`endif
                  end
               end
`ifdef BUS_TIMEOUT_EN
               else if (w_expired) begin
                  r_req       <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_we    <= r_we;
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b1;
                  r_state     <= S_RSP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
`endif
            end
            S_WAIT: begin
               if (RVALID) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_we    <= r_we;
                  r_rsp_rdata <= r_we ? '0 : RDATA;
`ifdef BUS_TIMEOUT_EN
                  r_rsp_err   <= 1'b0;
`endif
                  r_state     <= S_RSP;
               end
`ifdef BUS_TIMEOUT_EN
               else if (w_expired) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_we    <= r_we;
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b1;
                  r_state     <= S_RSP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
`endif
            end
            S_RSP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign REQ       = r_req;
   assign WE        = r_we;
   assign BE        = r_be;
   assign ADDR      = r_addr;
   assign WDATA     = r_wdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_we    = r_rsp_we;
   assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_bus_initiator.sv
// Scoreboard bench for bus_initiator with a behavioural responder holding byte-enabled registers.
module tb_bus_initiator;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [3:0]  cmd_be;
   logic [23:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_we;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        REQ;
   logic        WE;
   logic [3:0]  BE;
   logic [23:0] ADDR;
   logic [31:0] WDATA;
   logic        GNT;
   logic        RVALID;
   logic [31:0] RDATA;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [23:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      logic        we;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   req_t        exp_req_q[$];
   rsp_t        exp_rsp_q[$];
   logic [31:0] exp_mem [64];
   logic [31:0] rsp_mem [64];
   int          n_cmp = 0;
   int          n_mis = 0;
   int          rsp_cnt = 0;
   int unsigned gnt_dly = 0;
   int unsigned rv_dly = 0;
   bit          never_grant = 1'b0;

   always #5 clk = ~clk;

   bus_initiator #(
      .ADDR_W    (24),
      .DATA_W    (32),
      .CMD_DEPTH (4),
      .TIMEOUT   (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_we    (cmd_we),
      .cmd_be    (cmd_be),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_we    (rsp_we),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .REQ       (REQ),
      .WE        (WE),
      .BE        (BE),
      .ADDR      (ADDR),
      .WDATA     (WDATA),
      .GNT       (GNT),
      .RVALID    (RVALID),
      .RDATA     (RDATA)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
      end
      return r;
   endfunction

   // Offers one command; on acceptance records the expected bus request and completion.
   task automatic send_cmd(input logic we, input logic [3:0] be, input logic [23:0] addr,
                           input logic [31:0] wdata, input bit times_out);
      int unsigned t = 0;
      req_t rq;
      rsp_t rs;
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_be    = be;
      cmd_addr  = addr;
      cmd_wdata = wdata;
      while (!cmd_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!cmd_ready) begin
         check_val("cmd_accept_timeout", 1'b0, 1'b1);
         cmd_valid = 1'b0;
         return;
      end
      if (times_out) begin
         rs = '{we, 32'h0, 1'b1};
      end else begin
         rq = '{we, be, addr, wdata};
         exp_req_q.push_back(rq);
         if (we) begin
            exp_mem[addr[5:0]] = merge_be(exp_mem[addr[5:0]], wdata, be);
            rs = '{1'b1, 32'h0, 1'b0};
         end else begin
            rs = '{1'b0, exp_mem[addr[5:0]], 1'b0};
         end
      end
      exp_rsp_q.push_back(rs);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned t = 0;
      while ((exp_rsp_q.size() != 0 || rsp_valid) && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check_val("drain", exp_rsp_q.size(), 0);
      @(negedge clk);
   endtask

   // Responder: decides GNT/RVALID at each negedge for the following posedge.
   initial begin : responder
      int unsigned wcnt;
      int unsigned rcnt;
      bit          pend;
      logic [31:0] rd_val;
      req_t        e;
      wcnt = 0; rcnt = 0; pend = 1'b0; rd_val = '0;
      GNT = 1'b0; RVALID = 1'b0; RDATA = '0;
      forever begin
         @(negedge clk);
         GNT = 1'b0; RVALID = 1'b0; RDATA = '0;
         if (rst) begin
            wcnt = 0; rcnt = 0; pend = 1'b0;
         end else if (never_grant) begin
            if (!REQ) begin
               GNT = 1'b1; RVALID = 1'b1; RDATA = 32'hBAD0BAD0;
            end
         end else if (pend) begin
            if (rcnt >= rv_dly) begin
               RVALID = 1'b1; RDATA = rd_val; pend = 1'b0;
            end else begin
               rcnt++;
            end
         end else if (REQ) begin
            if (wcnt >= gnt_dly) begin
               if (exp_req_q.size() == 0) begin
                  check_val("req_unexpected", 1'b1, 1'b0);
               end else begin
                  e = exp_req_q.pop_front();
                  check_val("req_we", WE, e.we);
                  check_val("req_be", BE, e.be);
                  check_val("req_addr", ADDR, e.addr);
                  check_val("req_wdata", WDATA, e.wdata);
               end
               if (WE) begin
                  rsp_mem[ADDR[5:0]] = merge_be(rsp_mem[ADDR[5:0]], WDATA, BE);
                  rd_val = 32'hFFFF_FFFF;
               end else begin
                  rd_val = rsp_mem[ADDR[5:0]];
               end
               GNT = 1'b1;
               wcnt = 0;
               if (rv_dly == 0) begin
                  RVALID = 1'b1; RDATA = rd_val;
               end else begin
                  pend = 1'b1; rcnt = 1;
               end
            end else begin
               wcnt++;
            end
         end
      end
   end

   // Completion monitor, sampled just after the negedge so rsp_ready is settled.
   initial begin : monitor
      rsp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst && rsp_valid && rsp_ready) begin
            rsp_cnt++;
            if (exp_rsp_q.size() == 0) begin
               check_val("rsp_unexpected", 1'b1, 1'b0);
            end else begin
               e = exp_rsp_q.pop_front();
               check_val("rsp_we", rsp_we, e.we);
               check_val("rsp_rdata", rsp_rdata, e.rdata);
               check_val("rsp_err", rsp_err, e.err);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int unsigned t;
      int unsigned reqc;
      int          base;
      bit          ok;
      logic [31:0] held;
      for (int i = 0; i < 64; i++) begin
         exp_mem[i] = '0;
         rsp_mem[i] = '0;
      end
      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_be = '0; cmd_addr = '0;
      cmd_wdata = '0; rsp_ready = 1'b1;

      @(negedge clk);
      check_val("reset_req", REQ, 1'b0);
      check_val("reset_outputs_zero", |{REQ, WE, BE, ADDR, WDATA, rsp_valid, rsp_we,
                                        rsp_rdata, rsp_err, cmd_ready}, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1 check_val("ready_low_at_release", cmd_ready, 1'b0);
      @(negedge clk);
      check_val("ready_rises", cmd_ready, 1'b1);

      // Immediate responder, single write
      send_cmd(1'b1, 4'hF, 24'h000003, 32'hDEADBEEF, 1'b0);
      check_val("t1_req_before", REQ, 1'b0);
      @(negedge clk);
      check_val("t1_req", REQ, 1'b1);
      check_val("t1_we", WE, 1'b1);
      check_val("t1_be", BE, 4'hF);
      check_val("t1_addr", ADDR, 24'h000003);
      check_val("t1_wdata", WDATA, 32'hDEADBEEF);
      @(negedge clk);
      check_val("t1_req_drop", REQ, 1'b0);
      check_val("t1_rsp_valid", rsp_valid, 1'b1);
      wait_idle();

      // Partial write then read back
      send_cmd(1'b1, 4'b0101, 24'h000005, 32'hA5A5A5A5, 1'b0);
      send_cmd(1'b0, 4'hF, 24'h000005, 32'h0, 1'b0);
      wait_idle();

      // Delayed GNT then delayed RVALID
      gnt_dly = 3; rv_dly = 2;
      base = rsp_cnt; reqc = 0; ok = 1'b1; t = 0;
      send_cmd(1'b0, 4'hF, 24'h000005, 32'h0, 1'b0);
      while (rsp_cnt == base && t < 60) begin
         if (REQ) begin
            reqc++;
            if (ADDR !== 24'h000005 || WE !== 1'b0) ok = 1'b0;
         end
         @(negedge clk);
         t++;
      end
      check_val("t3_req_cycles", reqc, 4);
      check_val("t3_req_stable", ok, 1'b1);
      ok = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (REQ) ok = 1'b0;
      end
      check_val("t3_no_second_req", ok, 1'b1);
      check_val("t3_single_rsp", rsp_cnt - base, 1);
      wait_idle();

      // Fill the FIFO behind a stalled bus
      gnt_dly = 6; rv_dly = 0;
      send_cmd(1'b1, 4'hF, 24'h00000A, 32'h1111_0001, 1'b0);
      send_cmd(1'b1, 4'hF, 24'h00000B, 32'h2222_0002, 1'b0);
      send_cmd(1'b0, 4'hF, 24'h00000A, 32'h0, 1'b0);
      send_cmd(1'b1, 4'b1100, 24'h00000C, 32'h3333_0003, 1'b0);
      check_val("t4_ready_before_5th", cmd_ready, 1'b1);
      send_cmd(1'b0, 4'hF, 24'h00000B, 32'h0, 1'b0);
      check_val("t4_ready_full", cmd_ready, 1'b0);
      wait_idle();

      // Completion back-pressure with a queued command
      gnt_dly = 0; rv_dly = 0; rsp_ready = 1'b0;
      send_cmd(1'b0, 4'hF, 24'h000005, 32'h0, 1'b0);
      send_cmd(1'b1, 4'b0011, 24'h000009, 32'h1234_5678, 1'b0);
      t = 0;
      while (!rsp_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_val("t5_rsp_valid", rsp_valid, 1'b1);
      held = rsp_rdata; ok = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (REQ || !rsp_valid || rsp_rdata !== held || rsp_we !== 1'b0) ok = 1'b0;
      end
      check_val("t5_stall_stable", ok, 1'b1);
      check_val("t5_held_rdata", held, 32'h00A500A5);
      rsp_ready = 1'b1;
      @(negedge clk);
      check_val("t5_req_at_hs", REQ, 1'b0);
      @(negedge clk);
      check_val("t5_req_after_hs", REQ, 1'b1);
      wait_idle();

`ifdef BUS_TIMEOUT_EN
      // Responder never grants; spurious GNT/RVALID once REQ is low
      never_grant = 1'b1; rsp_ready = 1'b0; reqc = 0; t = 0;
      send_cmd(1'b0, 4'hF, 24'h000007, 32'h0, 1'b1);
      while (!rsp_valid && t < 60) begin
         if (REQ) reqc++;
         @(negedge clk);
         t++;
      end
      check_val("t6_req_cycles", reqc, 8);
      check_val("t6_rsp_err", rsp_err, 1'b1);
      check_val("t6_rsp_rdata", rsp_rdata, 32'h0);
      ok = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (REQ || !rsp_valid || !rsp_err) ok = 1'b0;
      end
      check_val("t6_late_gnt_ignored", ok, 1'b1);
      base = rsp_cnt;
      rsp_ready = 1'b1;
      wait_idle();
      ok = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (REQ || rsp_valid) ok = 1'b0;
      end
      check_val("t6_idle_after", ok, 1'b1);
      check_val("t6_single_rsp", rsp_cnt - base, 1);
      never_grant = 1'b0;
`endif

      // Reset while waiting for RVALID, with a second command queued
      gnt_dly = 0; rv_dly = 5; rsp_ready = 1'b1; base = rsp_cnt;
      send_cmd(1'b0, 4'hF, 24'h000005, 32'h0, 1'b0);
      send_cmd(1'b0, 4'hF, 24'h000006, 32'h0, 1'b0);
      @(negedge clk);
      check_val("t7_in_wait", {REQ, rsp_valid}, 2'b00);
      #1 rst = 1'b1;
      #1 check_val("t7_outputs_async_zero", |{REQ, WE, BE, ADDR, WDATA, rsp_valid, rsp_we,
                                              rsp_rdata, rsp_err, cmd_ready}, 1'b0);
      exp_req_q.delete();
      exp_rsp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 check_val("t7_ready_low_at_release", cmd_ready, 1'b0);
      ok = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (REQ || rsp_valid) ok = 1'b0;
      end
      check_val("t7_queue_lost", ok, 1'b1);
      check_val("t7_no_rsp", rsp_cnt - base, 0);
      check_val("t7_ready_back", cmd_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
